// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder/subtractor: one 4-bit ripple slice reused
// over NIBBLES cycles, valid/ready handshake on both sides.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 c_in,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] s,
    output logic                 c_out,
    output logic                 ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          carry;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    slice_sum;
    logic [4:0]    cy;
    logic          slice_ovf;

    // {k,2'b00} is exactly as wide as a bit index into W
    assign a_nib = op_a[{k, 2'b00} +: 4];
    assign b_nib = op_b[{k, 2'b00} +: 4];

    always_comb begin
        slice_sum = '0;
        cy        = '0;
        cy[0]     = carry;
        for (int i = 0; i < 4; i++) begin
            slice_sum[i] = a_nib[i] ^ b_nib[i] ^ cy[i];
            cy[i+1]      = (a_nib[i] & b_nib[i])
                         | (cy[i] & (a_nib[i] ^ b_nib[i]));
        end
    end

    // Only meaningful on the top nibble, where bit 3 is the sign bit
    assign slice_ovf = (a_nib[3] == b_nib[3]) && (slice_sum[3] != a_nib[3]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            s         <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= a;
                        op_b     <= sub ? ~b : b;
                        carry    <= sub ? 1'b1 : c_in;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    s[{k, 2'b00} +: 4] <= slice_sum;
                    carry              <= cy[4];
                    if (k == K_LAST) begin
                        k         <= '0;
                        c_out     <= cy[4];
                        ovf       <= slice_ovf;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    k         <= '0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
